// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b (LSB first) with start/busy/done handshake.
// Optional: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_o.
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf_o,
`endif
   output logic             borrow_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;

   logic             a0, b0, d_bit, bo_bit;
   logic [WIDTH-1:0] res_full;

   assign a0     = opa_q[0];
   assign b0     = opb_q[0];
   assign d_bit  = a0 ^ b0 ^ br_q;
   assign bo_bit = (~a0 & b0) | (~(a0 ^ b0) & br_q);
   // res_full is the result register with this cycle's bit shifted in at the MSB.
   assign res_full = {d_bit, res_q};

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d = S_SHIFT;
               opa_d   = a_i;
               opb_d   = b_i;
               res_d   = '0;
               br_d    = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            opa_d = opa_q >> 1;
            opb_d = opb_q >> 1;
            res_d = res_full[WIDTH-1:1];
            br_d  = bo_bit;
            if (cnt_q == CNT_LAST) begin
               state_d  = S_DONE;
               diff_d   = res_full;
               borrow_d = bo_bit;
`ifdef SERIAL_SUB_OVF_EN
               // On the last bit, a0/b0 are the operand sign bits.
               ovf_d    = (a0 ^ b0) & (d_bit ^ a0);
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
   assign ovf_o = ovf_q;
`endif

   assign busy_o   = (state_q == S_SHIFT);
   assign done_o   = (state_q == S_DONE);
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors with a per-cycle arithmetic reference model.
`default_nettype none

module tb_serial_subtractor;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         busy_o, done_o, borrow_o;
   logic [W-1:0] diff_o;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf_o;
`endif

   int errors = 0;
   int checks = 0;
   logic chk_en = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .diff_o   (diff_o),
`ifdef SERIAL_SUB_OVF_EN
      .ovf_o    (ovf_o),
`endif
      .borrow_o (borrow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic sovf(input logic [W-1:0] a, input logic [W-1:0] b);
      int r;
      r = int'($signed(a)) - int'($signed(b));
      return (r > (2**(W-1) - 1)) || (r < -(2**(W-1)));
   endfunction

   // Reference model: edges since acceptance (-1 = nothing in flight).
   int           m_age = -1;
   logic [W-1:0] m_pdiff = '0, m_diff = '0;
   logic         m_pbor = 1'b0, m_bor = 1'b0, m_povf = 1'b0, m_ovf = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_age  <= -1;
         m_diff <= '0;
         m_bor  <= 1'b0;
         m_ovf  <= 1'b0;
      end else if (m_age >= 0 && m_age < W) begin
         m_age <= m_age + 1;
         if (m_age == W - 1) begin
            m_diff <= m_pdiff;
            m_bor  <= m_pbor;
            m_ovf  <= m_povf;
         end
      end else if (start_i) begin
         m_age   <= 0;
         m_pdiff <= W'((int'(a_i) - int'(b_i)) & ((1 << W) - 1));
         m_pbor  <= (a_i < b_i);
         m_povf  <= sovf(a_i, b_i);
      end else begin
         m_age <= -1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy_o), 32'(m_age >= 0 && m_age < W));
         chk("done", 32'(done_o), 32'(m_age == W));
         chk("diff", 32'(diff_o), 32'(m_diff));
         chk("borrow", 32'(borrow_o), 32'(m_bor));
`ifdef SERIAL_SUB_OVF_EN
         chk("ovf", 32'(ovf_o), 32'(m_ovf));
`endif
      end
   end

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
      start_i = 1'b1;
      a_i = a;
      b_i = b;
      @(negedge clk);
      start_i = 1'b0;
      a_i = W'($urandom);
      b_i = W'($urandom);
   endtask

   task automatic wait_done(input string name, input logic [W-1:0] ed, input logic eb, input int inj);
      int lat = 1;
      while (!done_o && lat < W + 4) begin
         if (lat == inj) begin
            start_i = 1'b1;
            a_i = '0;
            b_i = '0;
         end
         @(negedge clk);
         start_i = 1'b0;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(W + 1));
      chk({name, "_diff"}, 32'(diff_o), 32'(ed));
      chk({name, "_borrow"}, 32'(borrow_o), 32'(eb));
   endtask

   task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ed, input logic eb);
      @(negedge clk);
      go(a, b);
      wait_done(name, ed, eb, 0);
   endtask

   int dones;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_diff", 32'(diff_o), 32'd0);
      chk("rst_borrow", 32'(borrow_o), 32'd0);
      rst_n = 1'b1;
      chk_en = 1'b1;

      op("t1", 8'd100, 8'd37, 8'd63, 1'b0);
      op("t2a", 8'd5, 8'd9, 8'hFC, 1'b1);
      op("t2b", 8'h00, 8'hFF, 8'h01, 1'b1);
      op("t2c", 8'hFF, 8'hFF, 8'h00, 1'b0);

      // start pulse mid-SHIFT must be ignored
      @(negedge clk);
      go(8'd200, 8'd1);
      wait_done("t3", 8'd199, 1'b0, 3);
      @(negedge clk);
      chk("t3_single_done", 32'(done_o), 32'd0);

      // back-to-back: accept again from the DONE cycle
      op("t4a", 8'd100, 8'd37, 8'd63, 1'b0);
      go(8'd10, 8'd20);
      chk("t4_no_idle_busy", 32'(busy_o), 32'd1);
      chk("t4_hold_diff", 32'(diff_o), 32'd63);
      wait_done("t4b", 8'hF6, 1'b1, 0);

      // asynchronous reset mid-SHIFT
      @(negedge clk);
      go(8'd50, 8'd7);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_busy", 32'(busy_o), 32'd0);
      chk("t5_done", 32'(done_o), 32'd0);
      chk("t5_diff", 32'(diff_o), 32'd0);
      chk("t5_borrow", 32'(borrow_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      chk("t5_no_done", 32'(dones), 32'd0);

      op("t6a", 8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      chk("t6a_ovf", 32'(ovf_o), 32'd1);
`endif
      op("t6b", 8'h7F, 8'hFF, 8'h80, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
      chk("t6b_ovf", 32'(ovf_o), 32'd1);
`endif
      op("t6c", 8'd100, 8'd37, 8'd63, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
      chk("t6c_ovf", 32'(ovf_o), 32'd0);
`endif

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b, one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow flip-flop. It is the inverse-direction companion to the team's combinational full adder, intended for area-constrained datapaths in the same design. A start/busy/done handshake controls it.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
a  input  WIDTH  minuend; sampled on the accepting edge only.
b  input  WIDTH  subtrahend; sampled on the accepting edge only.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse; diff/borrow valid from this cycle.
diff  output  WIDTH  (a - b) mod 2^WIDTH, registered.
borrow  output  1  final borrow-out; 1 iff a < b unsigned.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, diff=0, borrow=0; internal shift registers, borrow flop and bit counter all cleared.
- States: IDLE, SHIFT, DONE.
  - IDLE: on edge with start=1, load a into opa_sr, b into opb_sr, clear borrow flop and counter, go to SHIFT.
  - SHIFT: each edge processes bit 0 of opa_sr/opb_sr:
    - d = a0 ^ b0 ^ br.
    - bo = (~a0 & b0) | (~(a0 ^ b0) & br).
    - Shift d into MSB of res_sr (right shift). Shift opa_sr and opb_sr right. br <= bo. counter++.
    - On the edge processing bit WIDTH-1: diff <= final res_sr contents, borrow <= bo, go to DONE.
  - DONE: done=1 for exactly one cycle. Next edge: if start=1, accept new operands exactly as in IDLE and go to SHIFT; otherwise go to IDLE.
- Latency: start accepted at edge E. busy=1 from E to E+WIDTH. Result edge is E+WIDTH; done=1 during the cycle after E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- busy and done are registered, decoded from state, and never high together.
- start while busy: ignored. Operands, counter and the in-progress result are unaffected. No error flag.
- diff/borrow are updated only on the result edge. They hold the previous result throughout a following operation.
- a/b changes outside the accepting edge have no effect.
- Reset asserted mid-SHIFT: operation abandoned; all outputs to reset values immediately. No done pulse after release.
- Counter width: $clog2(WIDTH) bits; terminal count WIDTH-1. No wrap beyond terminal count.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined: adds output ovf (1 bit), the signed two's-complement overflow of a - b.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
  - Computed from the latched operand MSBs and the final result bit.
  - Registered on the result edge with diff. Reset value 0. Held like diff.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8. Assert rst_n=0 for 2 cycles, release. Start a=8'd100, b=8'd37 -> busy high 8 cycles; done pulses once exactly 8 cycles after the accepting edge; diff=8'd63, borrow=0.
2. a=8'd5, b=8'd9 -> diff=8'hFC, borrow=1. Then a=8'h00, b=8'hFF -> diff=8'h01, borrow=1. Then a=b=8'hFF -> diff=8'h00, borrow=0.
3. Start a=8'd200, b=8'd1. At cycle 3 of SHIFT, pulse start with a=0, b=0 -> ignored; diff=8'd199, borrow=0, single done pulse.
4. Hold start=1 through the DONE cycle with a=8'd10, b=8'd20 -> second operation accepted with no IDLE cycle. diff holds the first result until the second result edge, then diff=8'hF6, borrow=1.
5. Drop rst_n mid-SHIFT (cycle 4) -> busy, done, diff, borrow read 0 asynchronously. After release, no done pulse until a new start.
6. With SERIAL_SUB_OVF_EN: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1. a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1. a=8'd100, b=8'd37 -> ovf=0.
